// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice.
package full_adder_pkg;
  localparam int FA_MAX_WIDTH = 64;
endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; master drives operands, slave returns the sum.
interface full_adder_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] s;
  logic             cy;

  modport master (output a, b, c, input  s, cy);
  modport slave  (input  a, b, c, output s, cy);
endinterface

// File: rtl/full_adder_fa_cell.sv
// One-bit combinational full adder, the ripple element of full_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with an optional output register stage.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  full_adder_if.slave fa
);
  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] sum;

  assign k[0] = fa.c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (fa.a[i]),
      .b  (fa.b[i]),
      .ci (k[i]),
      .s  (sum[i]),
      .co (k[i+1])
    );
  end

  if (REG_OUT) begin : g_reg
    // Reset wins over the data update on the same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        fa.s  <= '0;
        fa.cy <= 1'b0;
      end else begin
        fa.s  <= sum;
        fa.cy <= k[WIDTH];
      end
    end
  end else begin : g_comb
    assign fa.s  = sum;
    assign fa.cy = k[WIDTH];
    // clk/rst have no role when the outputs are combinational.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: vector tables plus a scoreboard queue.
module tb_full_adder;
  typedef struct {
    logic [7:0] s;
    logic       cy;
  } exp_t;

  typedef struct {
    logic a, b, c;
    logic s, cy;
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       c;
    logic [7:0] s;
    logic       cy;
  } vec8_t;

  logic clk = 1'b0;
  logic rst;
  logic clk_c = 1'b0;
  logic rst_c;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();
  full_adder_if #(.WIDTH(4)) if4 ();
  full_adder_if #(.WIDTH(1)) ifc ();

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (.clk(clk),   .rst(rst),   .fa(if1));
  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (.clk(clk),   .rst(rst),   .fa(if8));
  full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (.clk(clk),   .rst(rst),   .fa(if4));
  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (.clk(clk_c), .rst(rst_c), .fa(ifc));

  task automatic push(input logic [7:0] s, input logic cy);
    exp_t e;
    e.s  = s;
    e.cy = cy;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act_s, input logic act_cy);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got s=%h cy=%b", name, act_s, act_cy);
      return;
    end
    e = sb.pop_front();
    if (act_s !== e.s || act_cy !== e.cy) begin
      errors++;
      $display("FAIL %s: got s=%h cy=%b, expected s=%h cy=%b", name, act_s, act_cy, e.s, e.cy);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic a, input logic b, input logic c);
    if1.a = a;
    if1.b = b;
    if1.c = c;
  endtask

  vec1_t tbl1[8];
  vec8_t tbl8[3];

  initial begin
    tbl1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl8[2] = '{8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0};

    rst   = 1'b1;
    rst_c = 1'b0;
    drive1(1'b0, 1'b0, 1'b0);
    if8.a = '0; if8.b = '0; if8.c = 1'b0;
    if4.a = '0; if4.b = '0; if4.c = 1'b0;
    ifc.a = 1'b0; ifc.b = 1'b0; ifc.c = 1'b0;
    tick();

    // Reset state of every registered instance.
    push(8'h00, 1'b0); check("reset_w1", {7'b0, if1.s}, if1.cy);
    push(8'h00, 1'b0); check("reset_w8", if8.s, if8.cy);
    push(8'h00, 1'b0); check("reset_w4", {4'b0, if4.s}, if4.cy);

    // Reset held with all-ones operands, then released.
    drive1(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      push(8'h00, 1'b0);
      tick();
      check("reset_hold", {7'b0, if1.s}, if1.cy);
    end
    rst = 1'b0;
    push(8'h01, 1'b1);
    tick();
    check("reset_release", {7'b0, if1.s}, if1.cy);

    // Exhaustive registered WIDTH=1 sweep.
    for (int i = 0; i < 8; i++) begin
      drive1(tbl1[i].a, tbl1[i].b, tbl1[i].c);
      push({7'b0, tbl1[i].s}, tbl1[i].cy);
      tick();
      check($sformatf("sweep_w1_%0d", i), {7'b0, if1.s}, if1.cy);
    end

    // Reset asserted on the same edge as a pending (1,0) result.
    drive1(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    push(8'h00, 1'b0);
    tick();
    check("midrst_edge", {7'b0, if1.s}, if1.cy);
    push(8'h00, 1'b0);
    tick();
    check("midrst_hold", {7'b0, if1.s}, if1.cy);
    rst = 1'b0;
    drive1(1'b0, 1'b0, 1'b0);
    push(8'h00, 1'b0);
    tick();
    check("midrst_release", {7'b0, if1.s}, if1.cy);

    // WIDTH=8 carry-chain corners.
    for (int i = 0; i < 3; i++) begin
      if8.a = tbl8[i].a;
      if8.b = tbl8[i].b;
      if8.c = tbl8[i].c;
      push(tbl8[i].s, tbl8[i].cy);
      tick();
      check($sformatf("w8_%0d", i), if8.s, if8.cy);
    end

    // Back-to-back random WIDTH=4 traffic.
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      logic [4:0] ref_sum;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
      if4.a = ra;
      if4.b = rb;
      if4.c = rc;
      push({4'b0, ref_sum[3:0]}, ref_sum[4]);
      tick();
      check("rand_w4", {4'b0, if4.s}, if4.cy);
    end

    // Combinational instance: no clock, rst toggled and ignored.
    for (int i = 0; i < 8; i++) begin
      rst_c = i[0];
      ifc.a = tbl1[i].a;
      ifc.b = tbl1[i].b;
      ifc.c = tbl1[i].c;
      push({7'b0, tbl1[i].s}, tbl1[i].cy);
      #5;
      check($sformatf("comb_w1_%0d", i), {7'b0, ifc.s}, ifc.cy);
      #5;
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
